// File: rtl/game_flow_ctrl.sv
// Game sequencer: level regeneration handshake, ball enable/recentre, BCD level/lives/seconds display.
// Define GAME_FLOW_PAUSE_EN to enable the pause button and the PAUSED state.
module game_flow_ctrl #(
  parameter int TICKS_PER_SEC = 60,
  parameter int LIVES         = 3,
  parameter int GRACE_FRAMES  = 30,
  parameter int HIT_FRAMES    = 45
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_btn_start,
  input  logic        i_btn_pause,
  input  logic        i_frame_tick,
  input  logic        i_zone_rdy,
  input  logic        i_ball_unsafe,
  input  logic        i_goal_reached,
  output logic        o_regenerate,
  output logic        o_ball_reset,
  output logic        o_ball_en,
  output logic [2:0]  o_state,
  output logic [31:0] o_disp_data
);

  localparam int FRAME_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int GRACE_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam int HIT_W   = (HIT_FRAMES > 0) ? $clog2(HIT_FRAMES + 1) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(TICKS_PER_SEC - 1);
  localparam logic [GRACE_W-1:0] GRACE_LOAD = GRACE_W'(GRACE_FRAMES);
  localparam logic [HIT_W-1:0]   HIT_LOAD   = HIT_W'(HIT_FRAMES);
  localparam logic [3:0]         LIVES_INIT = 4'(LIVES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GEN      = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_PLAY     = 3'd3,
    ST_HIT      = 3'd4,
    ST_OVER     = 3'd5,
    ST_PAUSED   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic                 start_q;
  logic                 arm_q, arm_d;
  logic [7:0]           level_q, level_d;
  logic [3:0]           lives_q, lives_d;
  logic [15:0]          sec_q, sec_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [GRACE_W-1:0]   grace_q, grace_d;
  logic [HIT_W-1:0]     hit_q, hit_d;
  logic                 regen_q, regen_d;
  logic                 ball_reset_q, ball_reset_d;
  logic                 ball_en_q, ball_en_d;
  logic [31:0]          disp_q, disp_d;
  logic                 start_edge;
  logic                 pause_edge;

  function automatic logic [7:0] bcd2_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)          r = v;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [15:0] bcd4_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign start_edge = i_btn_start & ~start_q;

`ifdef GAME_FLOW_PAUSE_EN
  logic pause_q;
  assign pause_edge = i_btn_pause & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = i_btn_pause;
  assign pause_edge   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    arm_d   = 1'b1;
    level_d = level_q;
    lives_d = lives_q;
    sec_d   = sec_q;
    frame_d = frame_q;
    grace_d = grace_q;
    hit_d   = hit_q;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) state_d = ST_GEN;
      end
      ST_GEN: begin
        state_d = ST_WAIT_RDY;
        arm_d   = 1'b0;
      end
      // rdy is disregarded in GEN and the first WAIT_RDY cycle while the generator drops it
      ST_WAIT_RDY: begin
        if (arm_q && i_zone_rdy) begin
          state_d = ST_PLAY;
          grace_d = GRACE_LOAD;
        end
      end
      ST_PLAY: begin
        if (pause_edge) begin
          state_d = ST_PAUSED;
        end else if (i_frame_tick) begin
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            sec_d   = bcd4_inc_sat(sec_q);
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
          if (grace_q != '0) begin
            grace_d = grace_q - GRACE_W'(1);
          end else if (i_goal_reached) begin
            level_d = bcd2_inc_sat(level_q);
            state_d = ST_GEN;
          end else if (i_ball_unsafe) begin
            lives_d = lives_q - 4'd1;
            if (lives_q == 4'd1) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_HIT;
              hit_d   = HIT_LOAD;
            end
          end
        end
      end
      ST_HIT: begin
        if (i_frame_tick) begin
          if (hit_q <= HIT_W'(1)) begin
            hit_d   = '0;
            state_d = ST_PLAY;
            grace_d = GRACE_LOAD;
          end else begin
            hit_d = hit_q - HIT_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (start_edge) begin
          level_d = 8'h01;
          lives_d = LIVES_INIT;
          sec_d   = '0;
          frame_d = '0;
          state_d = ST_GEN;
        end
      end
`ifdef GAME_FLOW_PAUSE_EN
      ST_PAUSED: begin
        if (pause_edge) state_d = ST_PLAY;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    regen_d      = (state_d == ST_GEN);
    ball_en_d    = (state_d == ST_PLAY);
    ball_reset_d = !((state_d == ST_PLAY) || (state_d == ST_PAUSED));
    disp_d       = {level_q, 4'h0, lives_q, sec_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b1;
      arm_q        <= 1'b0;
      level_q      <= 8'h01;
      lives_q      <= LIVES_INIT;
      sec_q        <= '0;
      frame_q      <= '0;
      grace_q      <= '0;
      hit_q        <= '0;
      regen_q      <= 1'b0;
      ball_reset_q <= 1'b1;
      ball_en_q    <= 1'b0;
      disp_q       <= {8'h01, 4'h0, LIVES_INIT, 16'h0000};
`ifdef GAME_FLOW_PAUSE_EN
      pause_q      <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      start_q      <= i_btn_start;
      arm_q        <= arm_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      sec_q        <= sec_d;
      frame_q      <= frame_d;
      grace_q      <= grace_d;
      hit_q        <= hit_d;
      regen_q      <= regen_d;
      ball_reset_q <= ball_reset_d;
      ball_en_q    <= ball_en_d;
      disp_q       <= disp_d;
`ifdef GAME_FLOW_PAUSE_EN
      pause_q      <= i_btn_pause;
`endif
    end
  end

  assign o_regenerate = regen_q;
  assign o_ball_reset = ball_reset_q;
  assign o_ball_en    = ball_en_q;
  assign o_state      = state_q;
  assign o_disp_data  = disp_q;

endmodule
